// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode constants and helpers.
package vga_pkg;

  typedef struct packed {
    int visible;
    int front;
    int sync;
    int back;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60_H = '{640, 16, 96, 48};
  localparam vga_timing_t VGA_640X480_60_V = '{480, 10, 2, 33};
  localparam vga_timing_t VGA_800X600_72_H = '{800, 56, 120, 64};
  localparam vga_timing_t VGA_800X600_72_V = '{600, 37, 6, 23};

  function automatic int total(vga_timing_t t);
    return t.visible + t.front + t.sync + t.back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with visible decode of the next
// position and a registered sync strobe aligned with the counter.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter vga_timing_t TIMING   = VGA_800X600_72_H,
  parameter bit          SYNC_POS = 1'b1,
  parameter int          W        = 11
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_adv,
  output logic [W-1:0] o_next,
  output logic         o_wrap,
  output logic         o_next_visible,
  output logic         o_sync_n
);

  localparam int TOTAL   = total(TIMING);
  localparam int SYNC_LO = TIMING.visible + TIMING.front;
  localparam int SYNC_HI = SYNC_LO + TIMING.sync - 1;

  logic [W-1:0] r_cnt;
  logic         w_sync_act;

  always_comb begin
    o_wrap = i_adv && (r_cnt == W'(TOTAL - 1));
    o_next = r_cnt;
    if (i_clr || o_wrap) begin
      o_next = '0;
    end else if (i_adv) begin
      o_next = r_cnt + 1'b1;
    end
    o_next_visible = !i_clr && (o_next < W'(TIMING.visible));
    w_sync_act     = !i_clr && (o_next >= W'(SYNC_LO)) && (o_next <= W'(SYNC_HI));
  end

  // Sync is decoded from the next count so it changes on the same edge as the counter.
  always_ff @(posedge i_clk) begin
    r_cnt    <= o_next;
    o_sync_n <= w_sync_act ? SYNC_POS : !SYNC_POS;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel divider, h/v axis counters and
// look-ahead coordinates, all outputs registered and aligned with (h,v).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = 800,
  parameter int H_FRONT    = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BACK     = 64,
  parameter int V_VISIBLE  = 600,
  parameter int V_FRONT    = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BACK     = 23,
  parameter int H_SYNC_POS = 1,
  parameter int V_SYNC_POS = 1,
  parameter int CLK_DIV    = 1,
  parameter int LEAD       = 1,
  parameter int X_W        = 11,
  parameter int Y_W        = 10
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Enable,
  output logic           blank_n,
  output logic           sync_n,
  output logic           hSync_n,
  output logic           vSync_n,
  output logic [X_W-1:0] nextX,
  output logic [Y_W-1:0] nextY,
  output logic           pixEn,
  output logic           lineStart,
  output logic           frameStart
);

  localparam vga_timing_t H_T = '{H_VISIBLE, H_FRONT, H_SYNC, H_BACK};
  localparam vga_timing_t V_T = '{V_VISIBLE, V_FRONT, V_SYNC, V_BACK};
  localparam int H_TOTAL = total(H_T);
  localparam int V_TOTAL = total(V_T);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          r_run;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_next;
  logic          w_clr;
  logic          w_adv;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_vis;
  logic          w_v_vis;
  logic          w_look_vis;
  int            w_lh;
  int            w_lv;

  assign sync_n = 1'b1;
  assign w_clr  = Reset || !Enable;

  always_comb begin
    w_div_next = (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
    w_adv      = r_run && (w_div_next == DW'(CLK_DIV - 1));
  end

  vga_axis_counter #(.TIMING(H_T), .SYNC_POS(H_SYNC_POS != 0), .W(HW)) u_h (
    .i_clk          (Clock),
    .i_clr          (w_clr),
    .i_adv          (w_adv),
    .o_next         (w_h_next),
    .o_wrap         (w_h_wrap),
    .o_next_visible (w_h_vis),
    .o_sync_n       (hSync_n)
  );

  vga_axis_counter #(.TIMING(V_T), .SYNC_POS(V_SYNC_POS != 0), .W(VW)) u_v (
    .i_clk          (Clock),
    .i_clr          (w_clr),
    .i_adv          (w_h_wrap),
    .o_next         (w_v_next),
    .o_wrap         (w_v_wrap),
    .o_next_visible (w_v_vis),
    .o_sync_n       (vSync_n)
  );

  // LEAD never exceeds the front porch, so at most one line wrap is needed.
  always_comb begin
    w_lh = int'(w_h_next) + LEAD;
    w_lv = int'(w_v_next);
    if (w_lh >= H_TOTAL) begin
      w_lh = w_lh - H_TOTAL;
      w_lv = w_lv + 1;
      if (w_lv >= V_TOTAL) begin
        w_lv = 0;
      end
    end
    w_look_vis = !w_clr && (w_lh < H_VISIBLE) && (w_lv < V_VISIBLE);
  end

  // The first enabled edge presents pixel (0,0) and preloads the divider so
  // that pixel lasts a full CLK_DIV clocks.
  always_ff @(posedge Clock) begin
    r_run <= !w_clr;
    if (w_clr) begin
      r_div <= '0;
    end else if (!r_run) begin
      r_div <= DW'(CLK_DIV - 1);
    end else begin
      r_div <= w_div_next;
    end
    blank_n    <= !w_clr && w_h_vis && w_v_vis;
    pixEn      <= !w_clr && (!r_run || w_adv);
    lineStart  <= !w_clr && w_h_wrap;
    frameStart <= !w_clr && w_h_wrap && w_v_wrap;
    nextX      <= w_look_vis ? X_W'(w_lh) : '0;
    nextY      <= w_look_vis ? Y_W'(w_lv) : '0;
  end

endmodule
